serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//  - Serial frame transmitter that drives the one-bit `data` line read by the
//    team's Mealy sequence detector.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Emits a fixed sync preamble, then the word MSB-first, one bit per clk.
//  - Then holds an idle gap so the detector sees clean frame boundaries.
// PARAMETERS
//  - WIDTH     8        payload bits per frame (>=1)
//  - PRE_LEN   4        preamble length in bits (0 = no preamble)
//  - PREAMBLE  4'b1001  preamble pattern, sent bit PRE_LEN-1 first (PRE_LEN bits wide)
//  - GAP_LEN   2        idle cycles after each frame (0 allowed)
// PORTS
//  - clk         in   1      single clock, all state on rising edge
//  - rst         in   1      asynchronous, active-low reset (0 = reset)
//  - load_valid  in   1      load_data is valid
//  - load_data   in   WIDTH  word to transmit
//  - load_ready  out  1      transmitter can accept a word (high only in IDLE)
//  - data        out  1      serial bit stream
//  - data_valid  out  1      data carries a preamble/payload/parity bit
//  - busy        out  1      frame in progress (any state but IDLE)
//  - done        out  1      high during the cycle the final frame bit is on data
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (rst=0, async, any time incl. mid-frame):
//    - state=IDLE; data=0, data_valid=0, busy=0, done=0, load_ready=1.
//    - The partial frame is abandoned, never resumed.
//  - FSM: IDLE -> PRE -> SHIFT -> [PAR] -> GAP -> IDLE.
//    - PRE is skipped if PRE_LEN=0.
//    - GAP is skipped if GAP_LEN=0.
//  - IDLE:
//    - data=0, data_valid=0, load_ready=1.
//    - On an edge with load_valid=1, capture load_data into the shift register.
//    - First frame bit appears on data on the next cycle (latency 1).
//  - PRE: PRE_LEN cycles, data=PREAMBLE[PRE_LEN-1-i], data_valid=1.
//  - SHIFT: WIDTH cycles, data=word[WIDTH-1-i] (MSB first), data_valid=1.
//  - GAP: GAP_LEN cycles, data=0, data_valid=0, busy=1.
//  - done=1 for exactly one cycle: the last SHIFT (or PAR) bit.
//  - Handshake:
//    - load_ready=0 whenever busy=1; load_valid is ignored then (no capture,
//      no queue).
//    - Changes to load_data after capture do not affect the frame.
//  - Frame period = 1 + PRE_LEN + WIDTH (+1 parity) + GAP_LEN cycles.
//  - Bit counter width: $clog2 of the largest phase length, min 1; it never
//    wraps, it is reloaded at every phase change.
// CONFIGURATION
//  - PARITY_EN defined:
//    - PAR state appended after SHIFT: 1 cycle, data = ^word (even parity),
//      data_valid=1, done=1.
//    - In this mode done is 0 on the last SHIFT bit.
//  - PARITY_EN undefined:
//    - No PAR state; frame is preamble + payload only.
//    - done coincides with the last payload bit.
// TESTING (WIDTH=8, PRE_LEN=4, PREAMBLE=4'b1001, GAP_LEN=2)
//  - Reset: rst=0 mid-frame.
//    -> same cycle data=0, data_valid=0, busy=0, load_ready=1.
//    -> After release, idle until a new load.
//  - Load 8'hA5:
//    -> data = 1,0,0,1, 1,0,1,0,0,1,0,1 with data_valid=1.
//    -> Then 2 cycles data_valid=0, load_ready back at cycle 15.
//    -> done only on the 12th bit.
//  - load_valid=1 with 8'hFF while busy:
//    -> ignored; the current frame is unchanged.
//    -> 8'hFF is sent only if load_valid is still high in IDLE.
//  - load_valid held high continuously, words 8'h01 then 8'h80:
//    -> back-to-back frames, exactly 1 IDLE cycle between them.
//  - PARITY_EN defined:
//    -> 8'hA5 is followed by parity bit 0 (done on it).
//    -> 8'h07 is followed by parity bit 1.
//  - PRE_LEN=0, GAP_LEN=0, load 8'h81:
//    -> data = 1,0,0,0,0,0,0,1 starting 1 cycle after capture.
//    -> load_ready=1 the following cycle.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: serial frame transmitter feeding a one-bit sequence detector.
// A word accepted over valid/ready goes out as: preamble, payload MSB-first,
// optional even-parity bit, then an idle gap. All outputs are registered.
// Optional feature: define PARITY_EN to append an even-parity bit to each frame.
module serial_pattern_tx #(
  parameter int WIDTH   = 8,
  parameter int PRE_LEN = 4,
  parameter logic [((PRE_LEN > 0) ? PRE_LEN : 1)-1:0] PREAMBLE = 4'b1001,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int PW    = (PRE_LEN > 0) ? PRE_LEN : 1;
  localparam int MAX1  = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int MAXL  = (GAP_LEN > MAX1) ? GAP_LEN : MAX1;
  localparam int CW    = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] PRE_LAST = CW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [CW-1:0] SH_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SHIFT,
    PAR,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  // Next-state, counter, shift registers and the registered output values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pre_d   = pre_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          sh_d  = load_data;
          pre_d = PREAMBLE;
          cnt_d = '0;
`ifdef PARITY_EN
          par_d = ^load_data;
`endif
          state_d = (PRE_LEN > 0) ? PRE : SHIFT;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          pre_d = pre_q << 1;
        end
      end
      SHIFT: begin
        if (cnt_q == SH_LAST) begin
          cnt_d = '0;
`ifdef PARITY_EN
          state_d = PAR;
`else
          state_d = (GAP_LEN > 0) ? GAP : IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = sh_q << 1;
        end
      end
      PAR: begin
        cnt_d   = '0;
        state_d = (GAP_LEN > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from where the FSM is going, so registering them
    // lines each bit up with the state that owns it.
    data_d       = 1'b0;
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    load_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    case (state_d)
      PRE: begin
        data_d       = pre_d[PW-1];
        data_valid_d = 1'b1;
      end
      SHIFT: begin
        data_d       = sh_d[WIDTH-1];
        data_valid_d = 1'b1;
`ifndef PARITY_EN
        done_d       = (cnt_d == SH_LAST);
`endif
      end
`ifdef PARITY_EN
      PAR: begin
        data_d       = par_d;
        data_valid_d = 1'b1;
        done_d       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload/preamble registers are reset too; they are small
      // flops, not a memory array, and a known value keeps data clean.
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      pre_q        <= '0;
      data_q       <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      pre_q        <= pre_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
`ifdef PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed bench for serial_pattern_tx, default
// parameters plus a PRE_LEN=0 / GAP_LEN=0 instance. Honours PARITY_EN.
module tb_serial_pattern_tx;

`ifdef PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  logic       clk;
  logic       rst;
  logic       load_valid, load_ready, data, data_valid, busy, done;
  logic [7:0] load_data;
  logic       load_valid_z, load_ready_z, data_z, data_valid_z, busy_z, done_z;
  logic [7:0] load_data_z;

  int n_checks = 0;
  int n_errors = 0;

  serial_pattern_tx dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .data(data), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  serial_pattern_tx #(.WIDTH(8), .PRE_LEN(0), .PREAMBLE(1'b0), .GAP_LEN(0)) dut_z (
    .clk(clk), .rst(rst), .load_valid(load_valid_z), .load_data(load_data_z),
    .load_ready(load_ready_z), .data(data_z), .data_valid(data_valid_z),
    .busy(busy_z), .done(done_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after capture; ends on the IDLE cycle after the gap.
  task automatic expect_frame(input logic [7:0] w, input logic p, input string tag);
    logic [12:0] bits;
    bits = {4'b1001, w, p};
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_data%0d", tag, i), data, bits[12-i]);
      check($sformatf("%s_valid%0d", tag, i), data_valid, 1'b1);
      check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      check($sformatf("%s_ready%0d", tag, i), load_ready, 1'b0);
      check($sformatf("%s_done%0d", tag, i), done, (i == NB - 1));
      step();
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_gap_valid%0d", tag, g), data_valid, 1'b0);
      check($sformatf("%s_gap_data%0d", tag, g), data, 1'b0);
      check($sformatf("%s_gap_busy%0d", tag, g), busy, 1'b1);
      check($sformatf("%s_gap_ready%0d", tag, g), load_ready, 1'b0);
      check($sformatf("%s_gap_done%0d", tag, g), done, 1'b0);
      step();
    end
    check({tag, "_idle_ready"}, load_ready, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_valid"}, data_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] zbits;
    rst = 1'b0;
    load_valid = 1'b0;
    load_data = 8'h00;
    load_valid_z = 1'b0;
    load_data_z = 8'h00;
    step();
    step();
    check("rst_data", data, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", load_ready, 1'b1);
    rst = 1'b1;
    step();
    step();
    check("idle_busy", busy, 1'b0);
    check("idle_ready", load_ready, 1'b1);

    // Plain frame; load_data changes right after capture.
    load_valid = 1'b1;
    load_data = 8'hA5;
    step();
    load_valid = 1'b0;
    load_data = 8'h00;
    expect_frame(8'hA5, 1'b0, "a5");

    // 8'hFF offered while busy is ignored, then taken in IDLE.
    load_valid = 1'b1;
    load_data = 8'h5A;
    step();
    load_data = 8'hFF;
    expect_frame(8'h5A, 1'b0, "5a");
    step();
    load_valid = 1'b0;
    expect_frame(8'hFF, 1'b0, "ff");

    // load_valid held high: back-to-back frames with one IDLE cycle.
    load_valid = 1'b1;
    load_data = 8'h01;
    step();
    load_data = 8'h80;
    expect_frame(8'h01, 1'b1, "b01");
    step();
    load_valid = 1'b0;
    expect_frame(8'h80, 1'b1, "b80");

    load_valid = 1'b1;
    load_data = 8'h07;
    step();
    load_valid = 1'b0;
    expect_frame(8'h07, 1'b1, "07");

    // Asynchronous reset mid-frame.
    load_valid = 1'b1;
    load_data = 8'hA5;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_valid_before_rst", data_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_data", data, 1'b0);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", load_ready, 1'b1);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_valid", data_valid, 1'b0);
    check("post_rst_ready", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data = 8'hC3;
    step();
    load_valid = 1'b0;
    expect_frame(8'hC3, 1'b0, "c3");

    // No preamble, no gap.
    zbits = 8'b1000_0001;
    load_valid_z = 1'b1;
    load_data_z = 8'h81;
    step();
    load_valid_z = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("z_data%0d", i), data_z, zbits[7-i]);
      check($sformatf("z_valid%0d", i), data_valid_z, 1'b1);
      check($sformatf("z_busy%0d", i), busy_z, 1'b1);
`ifdef PARITY_EN
      check($sformatf("z_done%0d", i), done_z, 1'b0);
`else
      check($sformatf("z_done%0d", i), done_z, (i == 7));
`endif
      step();
    end
`ifdef PARITY_EN
    check("z_par_data", data_z, 1'b0);
    check("z_par_done", done_z, 1'b1);
    step();
`endif
    check("z_ready", load_ready_z, 1'b1);
    check("z_busy_end", busy_z, 1'b0);
    check("z_valid_end", data_valid_z, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
